// File: rtl/pkg_sfrs_definition.sv
// Shared SFR-side definitions: timer register offsets and alarm scheduler state encoding.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package pkg_sfrs_definition;

    // Timer SFR offsets relative to the timer base address.
    localparam int TMR_VAL_OFS   = 4;
    localparam int TMR_MVAL0_OFS = 8;

    typedef enum logic [2:0] {
        TS_IDLE    = 3'd0,
        TS_BUS_REQ = 3'd1,
        TS_WR_MVAL = 3'd2,
        TS_RD_ADDR = 3'd3,
        TS_RD_DATA = 3'd4,
        TS_ARMED   = 3'd5,
        TS_FIRE    = 3'd6
    } tmr_sched_state_t;

    // States in which the scheduler keeps bus ownership requested.
    function automatic logic sched_holds_bus(input tmr_sched_state_t s);
        return (s == TS_BUS_REQ) || (s == TS_WR_MVAL) || (s == TS_RD_ADDR) || (s == TS_RD_DATA);
    endfunction

    // States in which an SFR access (address, maybe write strobe) is driven.
    function automatic logic sched_drives_sfr(input tmr_sched_state_t s);
        return (s == TS_WR_MVAL) || (s == TS_RD_ADDR) || (s == TS_RD_DATA);
    endfunction

endpackage

// File: rtl/sync_fifo_v1.sv
// Generic synchronous FIFO with first-word fall-through head, count and flush.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; flush wins over push/pop.
//
// Ports: clk/rst (sync, active-high), flush (sync clear), push/push_dat,
//        pop, head_dat (oldest entry), full, empty, count (0..DEPTH).
module sync_fifo_v1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem[rd_ptr];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/tmr_alarm_sched_v1.sv
// Multiplexes queued one-shot alarms onto the timer's single match-0 comparator via SFR writes.
// Latency: push into idle block -> bus_req +2, MVAL0 write +3, late alarm +6; on-time alarm 2 cycles after match0_event.
// Backpressure: req_ready low while the queue is full; SFR sequence stalls in place while bus_gnt is low.
//
// Ports: sys_clk/sys_rst (sync, active-high), sys_clk_en (global hold), flush (clear + abort),
//        req_valid/req_ready/req_deadline/req_id (alarm push), bus_req/bus_gnt (arbitration),
//        tmr_addr/tmr_wr_en/tmr_wdata/tmr_rdata (timer SFR master), match0_event (timer pulse),
//        alarm_valid/alarm_id/alarm_late (retire pulse), busy.
module tmr_alarm_sched_v1
    import pkg_sfrs_definition::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] TMR_BASE_ADDR = '0,
    parameter int                    DEPTH         = 4,
    parameter int                    ID_W          = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sys_clk_en,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_deadline,
    input  logic [ID_W-1:0]       req_id,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [ADDR_WIDTH-1:0] tmr_addr,
    output logic                  tmr_wr_en,
    output logic [DATA_WIDTH-1:0] tmr_wdata,
    input  logic [DATA_WIDTH-1:0] tmr_rdata,
    input  logic                  match0_event,
    output logic                  alarm_valid,
    output logic [ID_W-1:0]       alarm_id,
    output logic                  alarm_late,
    output logic                  busy
);
    localparam int FW = ID_W + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_VAL   = TMR_BASE_ADDR + ADDR_WIDTH'(TMR_VAL_OFS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MVAL0 = TMR_BASE_ADDR + ADDR_WIDTH'(TMR_MVAL0_OFS);

    // Queue
    logic [FW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_deadline;
    logic [ID_W-1:0]       head_id;

    // FSM and side state
    tmr_sched_state_t      state_q;
    tmr_sched_state_t      state_d;
    logic                  drv_q;   // an SFR access is on the bus this cycle
    logic                  drv_d;
    logic                  hit_q;   // match seen while the new match value is being verified
    logic                  evt_q;   // match seen while ARMED, retired next cycle
    logic                  late_d;
    logic                  phase_ok;
    logic [DATA_WIDTH-1:0] diff;
    logic [CW-1:0]         cnt_d;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full && sys_clk_en && !flush;
    assign pop       = (state_q == TS_FIRE) && sys_clk_en && !flush;
    assign {head_id, head_deadline} = fifo_head;

    sync_fifo_v1 #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .flush    (flush && sys_clk_en),
        .push     (push),
        .push_dat ({req_id, req_deadline}),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // A bus phase only completes when its access was actually presented while granted;
    // otherwise the state is held and the access is re-presented once the grant returns.
    assign phase_ok = drv_q && bus_gnt;

    // Modulo difference: top bit set or zero means the deadline is not in the future.
    assign diff = head_deadline - tmr_rdata;

    always_comb begin
        state_d = state_q;
        late_d  = 1'b0;
        case (state_q)
            TS_IDLE: begin
                if (!fifo_empty) begin
                    state_d = TS_BUS_REQ;
                end
            end
            TS_BUS_REQ: begin
                if (bus_gnt) begin
                    state_d = TS_WR_MVAL;
                end
            end
            TS_WR_MVAL: begin
                if (phase_ok) begin
                    state_d = TS_RD_ADDR;
                end
            end
            TS_RD_ADDR: begin
                if (phase_ok) begin
                    state_d = TS_RD_DATA;
                end
            end
            TS_RD_DATA: begin
                if (phase_ok) begin
                    if (hit_q || match0_event) begin
                        state_d = TS_FIRE;
                    end else if (diff[DATA_WIDTH-1] || (diff == '0)) begin
                        state_d = TS_FIRE;
                        late_d  = 1'b1;
                    end else begin
                        state_d = TS_ARMED;
                    end
                end
            end
            TS_ARMED: begin
                if (evt_q) begin
                    state_d = TS_FIRE;
                end
            end
            TS_FIRE: begin
                state_d = TS_IDLE;
            end
            default: begin
                state_d = TS_IDLE;
            end
        endcase
    end

    assign drv_d = sched_drives_sfr(state_d) && bus_gnt;

    always_comb begin
        cnt_d = fifo_cnt;
        if (push && !pop) begin
            cnt_d = fifo_cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_d = fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || (sys_clk_en && flush)) begin
            state_q     <= TS_IDLE;
            drv_q       <= 1'b0;
            hit_q       <= 1'b0;
            evt_q       <= 1'b0;
            bus_req     <= 1'b0;
            tmr_addr    <= '0;
            tmr_wr_en   <= 1'b0;
            tmr_wdata   <= '0;
            alarm_valid <= 1'b0;
            alarm_id    <= '0;
            alarm_late  <= 1'b0;
            busy        <= 1'b0;
        end else if (sys_clk_en) begin
            state_q <= state_d;
            drv_q   <= drv_d;
            // Matches before the new value is written belong to the old match value.
            if ((state_q == TS_RD_ADDR) || (state_q == TS_RD_DATA)) begin
                hit_q <= hit_q || match0_event;
            end else begin
                hit_q <= 1'b0;
            end
            evt_q <= match0_event && (state_q == TS_ARMED);

            bus_req   <= sched_holds_bus(state_d);
            tmr_addr  <= !drv_d ? '0 : ((state_d == TS_WR_MVAL) ? ADDR_MVAL0 : ADDR_VAL);
            tmr_wr_en <= drv_d && (state_d == TS_WR_MVAL);
            tmr_wdata <= (drv_d && (state_d == TS_WR_MVAL)) ? head_deadline : '0;

            alarm_valid <= (state_d == TS_FIRE);
            alarm_id    <= (state_d == TS_FIRE) ? head_id : '0;
            alarm_late  <= late_d;
            busy        <= (cnt_d != '0) || (state_d != TS_IDLE);
        end
    end

endmodule
